// File: rtl/increment_loader.sv
// rtl/increment_loader.sv - serial 3-wire increment word loader for the fractional divider (optional LOADER_PARITY_EN)
module increment_loader #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DEFAULT_INC = WIDTH'(85)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cs_n,
  input  logic             i_sclk,
  input  logic             i_sdata,
  output logic [WIDTH-1:0] o_incriment,
  output logic             o_load,
  output logic             o_busy,
  output logic             o_frame_err
);

`ifdef LOADER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 2);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0] SAT_C       = CW'(FRAME_LEN + 1);
  localparam logic [CW-1:0] WIDTH_C     = CW'(WIDTH);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
  // Marks which sync/prev stages hold a real pin sample rather than the reset preset.
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       inc_q, inc_d;
  logic                   load_q, load_d;
  logic                   err_q, err_d;
`ifdef LOADER_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic cs_cur, sclk_cur, sdata_cur;
  logic cs_fall, cs_rise, sclk_rise;
  logic frame_ok;

  assign cs_cur    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_cur  = sclk_sync_q[SYNC_STAGES-1];
  assign sdata_cur = sdata_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_cur;
  assign cs_rise   = ~cs_prev_q & cs_cur;
  assign sclk_rise = ~sclk_prev_q & sclk_cur;

`ifdef LOADER_PARITY_EN
  assign frame_ok = (count_q == FRAME_LEN_C) && ((^shreg_q ^ parity_q) == 1'b0);
`else
  assign frame_ok = (count_q == FRAME_LEN_C);
`endif

  // Pin synchronizers plus one extra registered copy for edge detection.
  always_comb begin
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], i_sdata};
    vld_d        = {vld_q[SYNC_STAGES-1:0], 1'b1};
    cs_prev_d    = cs_cur;
    sclk_prev_d  = sclk_cur;
  end

  // Frame state machine: boot load, wait for a genuine cs_n fall, shift, then judge the frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    inc_d   = inc_q;
    load_d  = 1'b0;
    err_d   = err_q;
`ifdef LOADER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_BOOT: begin
        load_d  = 1'b1;
        inc_d   = DEFAULT_INC;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // The previous copy must be a real sample so a preset 1 cannot fake a falling edge.
        if (cs_fall && vld_q[SYNC_STAGES]) begin
          shreg_d = '0;
          count_d = '0;
`ifdef LOADER_PARITY_EN
          parity_d = 1'b0;
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cs_n rising wins over a coincident sclk edge.
        if (cs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          if (count_q < WIDTH_C) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdata_cur};
          end
`ifdef LOADER_PARITY_EN
          else if (count_q == WIDTH_C) begin
            parity_d = sdata_cur;
          end
`endif
          if (count_q != SAT_C) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (frame_ok) begin
          inc_d  = shreg_q;
          load_d = 1'b1;
          err_d  = 1'b0;
        end else begin
          err_d  = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cs_sync_q    <= '1;
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      vld_q        <= '0;
      cs_prev_q    <= 1'b1;
      sclk_prev_q  <= 1'b0;
      state_q      <= ST_BOOT;
      shreg_q      <= '0;
      count_q      <= '0;
      inc_q        <= DEFAULT_INC;
      load_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      cs_sync_q    <= cs_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
      vld_q        <= vld_d;
      cs_prev_q    <= cs_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      inc_q        <= inc_d;
      load_q       <= load_d;
      err_q        <= err_d;
`ifdef LOADER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign o_incriment = inc_q;
  assign o_load      = load_q;
  assign o_busy      = (state_q == ST_SHIFT);
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_increment_loader.sv
// tb/tb_increment_loader.sv - self-checking bench for increment_loader with a frame-level reference model
module tb_increment_loader;
  localparam int W = 32;
`ifdef LOADER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cs_n = 1'b1;
  logic         sclk = 1'b0;
  logic         sdata = 1'b0;
  logic [W-1:0] o_incriment;
  logic         o_load;
  logic         o_busy;
  logic         o_frame_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_inc = 32'd85;
  logic         model_err = 1'b0;

  increment_loader dut (
    .i_clk       (clk),
    .i_reset_n   (rstn),
    .i_cs_n      (cs_n),
    .i_sclk      (sclk),
    .i_sdata     (sdata),
    .o_incriment (o_incriment),
    .o_load      (o_load),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends n sclk bits MSB first; bit W is the parity bit, later bits are random.
  // With clash set, one extra sclk rise is issued together with the cs_n rise.
  task automatic send_frame(input int n, input logic [W-1:0] data, input logic par,
                            input int hp, input bit clash);
    int loads = 0;
    int at = -1;
    bit exp_ok;
    cs_n = 1'b0;
    cyc(4);
    check("busy_in_frame", o_busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i < W) sdata = data[W-1-i];
      else if (i == W) sdata = par;
      else sdata = 1'($urandom_range(0, 1));
      cyc(hp);
      sclk = 1'b1;
      cyc(hp);
      sclk = 1'b0;
    end
    sdata = 1'($urandom_range(0, 1));
    cyc(hp);
    if (clash) sclk = 1'b1;
    cs_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (c == 2) sclk = 1'b0;
      if (o_load === 1'b1) begin
        loads++;
        at = c;
      end
    end
`ifdef LOADER_PARITY_EN
    exp_ok = (n == FL) && ((^data ^ par) == 1'b0);
`else
    exp_ok = (n == FL);
`endif
    if (exp_ok) begin
      model_inc = data;
      model_err = 1'b0;
    end else begin
      model_err = 1'b1;
    end
    check("load_count", loads, exp_ok ? 1 : 0);
    if (exp_ok) check("load_latency", at, 4);
    check("incriment", o_incriment, model_inc);
    check("frame_err", o_frame_err, model_err);
    check("busy_after", o_busy, 1'b0);
    cyc(4);
  endtask

  initial begin
    int kind, n, hp;
    logic [W-1:0] d;
    logic p;
    bit clash_seen;

    // Reset held 4 cycles, then boot load of the default increment.
    rstn = 1'b0;
    cyc(4);
    check("rst_inc", o_incriment, 32'd85);
    check("rst_load", o_load, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_frame_err, 1'b0);
    rstn = 1'b1;
    cyc(1);
    check("boot_load", o_load, 1'b1);
    check("boot_inc", o_incriment, 32'd85);
    cyc(1);
    check("boot_load_single", o_load, 1'b0);
    check("boot_err", o_frame_err, 1'b0);
    cyc(6);

`ifdef LOADER_PARITY_EN
    send_frame(FL, 32'h0000_0001, 1'b1, 4, 1'b0);
    send_frame(FL, 32'h0000_0001, 1'b0, 4, 1'b0);
    send_frame(FL, 32'h0000_0ABC, ^32'h0000_0ABC, 4, 1'b0);
`else
    send_frame(FL, 32'h0000_0ABC, 1'b0, 4, 1'b0);
    send_frame(FL - 1, 32'h1111_2222, 1'b0, 4, 1'b0);
    send_frame(FL, 32'h1234_5678, 1'b0, 4, 1'b0);
`endif
    send_frame(FL + 1, 32'hCAFE_F00D, ^32'hCAFE_F00D, 4, 1'b0);
    send_frame(0, 32'h0, 1'b0, 3, 1'b0);
    // A coincident sclk rise at cs_n rise must not count as an extra bit.
    send_frame(FL, 32'hA5A5_0F0F, ^32'hA5A5_0F0F, 3, 1'b1);

    // Reset in the middle of a frame with cs_n still low.
    cs_n = 1'b0;
    cyc(4);
    for (int i = 0; i < 16; i++) begin
      sdata = 1'($urandom_range(0, 1));
      cyc(3); sclk = 1'b1; cyc(3); sclk = 1'b0;
    end
    rstn = 1'b0;
    cyc(4);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_inc", o_incriment, 32'd85);
    rstn = 1'b1;
    cyc(1);
    check("midrst_boot_load", o_load, 1'b1);
    check("midrst_boot_inc", o_incriment, 32'd85);
    model_inc = 32'd85;
    model_err = 1'b0;
    clash_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(3); sclk = 1'b1; cyc(3); sclk = 1'b0;
      if (o_busy !== 1'b0 || o_load !== 1'b0) clash_seen = 1'b1;
    end
    check("cs_low_at_release_no_frame", clash_seen, 1'b0);
    cs_n = 1'b1;
    cyc(6);
    send_frame(FL, 32'h0BAD_BEEF, ^32'h0BAD_BEEF, 4, 1'b0);

    // Randomized frames against the model.
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: n = FL;
        2:    n = FL - 1;
        3:    n = FL + 1;
        4:    n = 0;
        default: n = $urandom_range(1, FL + 3);
      endcase
      d  = $urandom;
      p  = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      hp = $urandom_range(2, 5);
      send_frame(n, d, p, hp, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
